// File: rtl/conv_check.sv
// Convergence checker: streams N*N (new, previous) weight pairs through a 3-stage
// |.|-difference pipeline and flags convergence by max-abs or sum-abs error.
module conv_check #(
    parameter int N        = 4,
    parameter int W        = 26,
    parameter int MAX_ITER = 200,
    localparam int ACC_W   = W + $clog2(N * N),
    localparam int IW      = $clog2(MAX_ITER + 1)
) (
    input  logic             clk_err,
    input  logic             rstn_err,
    input  logic             start,
    input  logic             mode,
    input  logic [ACC_W-1:0] tol,
    input  logic             clr_iter,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_new,
    input  logic [W-1:0]     in_ica,
    output logic             busy,
    output logic             done,
    output logic             is_converge,
    output logic [ACC_W-1:0] err_out,
    output logic [IW-1:0]    iter_cnt,
    output logic             timeout,
    output logic [1:0]       state_dbg
);

    // Handshake: an element moves on a rising edge where in_valid && in_ready;
    // in_ready is high only in RUN, so nothing transfers after the last element.

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

    localparam int            CW      = $clog2(N * N) + 1;
    localparam logic [CW-1:0] LAST    = CW'(N * N - 1);
    localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]  MAX_POS = {1'b0, {(W-1){1'b1}}};

    // The most negative value has no positive twin, so it clamps to the largest positive.
    function automatic logic [W-1:0] abs_sat(input logic [W-1:0] x);
        if (x == MIN_NEG)  abs_sat = MAX_POS;
        else if (x[W-1])   abs_sat = ~x + W'(1);
        else               abs_sat = x;
    endfunction

    state_t           state, state_nxt;
    logic [CW-1:0]    elem_cnt;
    logic [1:0]       drain_cnt;
    logic             mode_q;
    logic [ACC_W-1:0] tol_q;
    logic             v1, v2;
    logic [W-1:0]     a_q, b_q;
    logic [W:0]       d_q, max_q;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] err_q;
    logic             conv_q;
    logic [IW-1:0]    iter_q;

    logic             xfer, start_frame;
    logic [W:0]       diff, d_abs;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] sum_nxt, metric;
    logic             conv_now;

    assign xfer        = in_valid && (state == RUN);
    assign start_frame = start && (state == IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (xfer && elem_cnt == LAST) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_err or negedge rstn_err) begin
        if (!rstn_err) begin
            state     <= IDLE;
            elem_cnt  <= '0;
            drain_cnt <= '0;
            mode_q    <= 1'b0;
            tol_q     <= '0;
        end else begin
            state <= state_nxt;
            if (start_frame) begin
                mode_q   <= mode;
                tol_q    <= tol;
                elem_cnt <= '0;
            end else if (xfer) begin
                elem_cnt <= elem_cnt + CW'(1);
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    // Both magnitudes are below 2^(W-1), so the W+1-bit difference never overflows.
    assign diff    = {1'b0, a_q} - {1'b0, b_q};
    assign d_abs   = diff[W] ? (~diff + (W+1)'(1)) : diff;
    assign sum_ext = {1'b0, sum_q} + {{(ACC_W-W){1'b0}}, d_q};
    assign sum_nxt = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];

    always_ff @(posedge clk_err or negedge rstn_err) begin
        if (!rstn_err) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            d_q   <= '0;
            max_q <= '0;
            sum_q <= '0;
        end else begin
            v1 <= xfer;
            v2 <= v1;
            if (xfer) begin
                a_q <= abs_sat(in_new);
                b_q <= abs_sat(in_ica);
            end
            if (v1) d_q <= d_abs;
            if (start_frame) begin
                max_q <= '0;
                sum_q <= '0;
            end else if (v2) begin
                if (d_q > max_q) max_q <= d_q;
                sum_q <= sum_nxt;
            end
        end
    end

    assign metric   = mode_q ? sum_q : {{(ACC_W-W-1){1'b0}}, max_q};
    assign conv_now = metric < tol_q;

    always_ff @(posedge clk_err or negedge rstn_err) begin
        if (!rstn_err) begin
            err_q  <= '0;
            conv_q <= 1'b0;
            iter_q <= '0;
        end else begin
            if (state == DONE) begin
                err_q  <= metric;
                conv_q <= conv_now;
            end
            if (clr_iter)
                iter_q <= '0;
            else if (state == DONE)
                iter_q <= conv_now ? '0 :
                          (iter_q == IW'(MAX_ITER)) ? iter_q : iter_q + IW'(1);
        end
    end

    // Results are visible combinationally during DONE, then held from the registers.
    assign in_ready    = (state == RUN);
    assign busy        = (state != IDLE);
    assign done        = (state == DONE);
    assign err_out     = done ? metric : err_q;
    assign is_converge = done ? conv_now : conv_q;
    assign iter_cnt    = iter_q;
    assign timeout     = (iter_q == IW'(MAX_ITER));
    assign state_dbg   = state;

endmodule
